// File: rtl/alu_issue_pkg.sv
// alu_issue shared definitions: ALU codes, RV32I opcodes,
// skid-buffer states and the issue bundle.
package alu_issue_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam logic [5:0] ALU_ADD  = 6'b000000;
   localparam logic [5:0] ALU_SUB  = 6'b001000;
   localparam logic [5:0] ALU_SLT  = 6'b000010;
   localparam logic [5:0] ALU_SLTU = 6'b000011;
   localparam logic [5:0] ALU_BLTU = 6'b010110;
   localparam logic [5:0] ALU_BGE  = 6'b010101;
   localparam logic [5:0] ALU_BGEU = 6'b010111;
   localparam logic [5:0] ALU_BEQ  = 6'b010000;
   localparam logic [5:0] ALU_BNE  = 6'b010001;
   localparam logic [5:0] ALU_OR   = 6'b000110;
   localparam logic [5:0] ALU_XOR  = 6'b000100;
   localparam logic [5:0] ALU_AND  = 6'b000111;
   localparam logic [5:0] ALU_SLL  = 6'b000001;
   localparam logic [5:0] ALU_SRL  = 6'b000101;
   localparam logic [5:0] ALU_SRA  = 6'b001101;
   localparam logic [5:0] ALU_JAL  = 6'b011111;
   localparam logic [5:0] ALU_JALR = 6'b111111;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      SKID_EMPTY,
      SKID_ONE,
      SKID_TWO
   } skid_state_e;

   typedef struct packed {
      logic [5:0]      alu_ctrl;
      logic [XLEN-1:0] op_a;
      logic [XLEN-1:0] op_b;
      logic            branch_op;
      logic [XLEN-1:0] target;
      logic [RAW-1:0]  rd;
      logic            reg_write;
      logic            illegal;
   } issue_t;

   // funct3 to ALU code for register and immediate arithmetic
   function automatic logic [5:0] arith_ctrl(
      input logic [2:0] f3,
      input logic       alt
   );
      logic [5:0] c;
      case (f3)
         3'b000:  c = alt ? ALU_SUB : ALU_ADD;
         3'b001:  c = ALU_SLL;
         3'b010:  c = ALU_SLT;
         3'b011:  c = ALU_SLTU;
         3'b100:  c = ALU_XOR;
         3'b101:  c = alt ? ALU_SRA : ALU_SRL;
         3'b110:  c = ALU_OR;
         default: c = ALU_AND;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_issue_skid_buffer.sv
// issue_skid_buffer: 2-entry valid/ready buffer over issue_t.
// in_ready is a flop; the head entry drives the output.
module issue_skid_buffer
   import alu_issue_pkg::*;
(
   input  logic   clock,
   input  logic   reset_n,
   input  logic   flush,
   input  logic   in_valid,
   output logic   in_ready,
   input  issue_t in_data,
   output logic   out_valid,
   input  logic   out_ready,
   output issue_t out_data
);

   skid_state_e state_q, state_d;
   issue_t      head_q, tail_q;
   logic        rdy_q;
   logic        push, pop;
   logic        ld_head, ld_tail, head_from_tail;

   assign push      = in_valid & rdy_q & ~flush;
   assign out_valid = (state_q != SKID_EMPTY);
   assign pop       = out_valid & out_ready;
   assign in_ready  = rdy_q;
   assign out_data  = head_q;

   // next-state and entry load decisions
   always_comb begin
      state_d        = state_q;
      ld_head        = 1'b0;
      ld_tail        = 1'b0;
      head_from_tail = 1'b0;
      unique case (state_q)
         SKID_EMPTY: begin
            if (push) begin
               state_d = SKID_ONE;
               ld_head = 1'b1;
            end
         end
         SKID_ONE: begin
            if (push && pop) begin
               ld_head = 1'b1;
            end else if (push) begin
               state_d = SKID_TWO;
               ld_tail = 1'b1;
            end else if (pop) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (pop) begin
               state_d        = SKID_ONE;
               ld_head        = 1'b1;
               head_from_tail = 1'b1;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      if (flush) state_d = SKID_EMPTY;
   end

   // state register and registered ready
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SKID_EMPTY;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != SKID_TWO);
      end
   end

   // entry storage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (ld_head) head_q <= head_from_tail ? tail_q : in_data;
         if (ld_tail) tail_q <= in_data;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue into the execute-stage ALU
// bundle, buffered through a 2-entry skid buffer.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instruction,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [5:0]            ALU_Control,
   output logic [DATA_WIDTH-1:0] operand_A,
   output logic [DATA_WIDTH-1:0] operand_B,
   output logic                  branch_op,
   output logic [DATA_WIDTH-1:0] target,
   output logic [REG_ADDR_W-1:0] rd,
   output logic                  reg_write,
   output logic                  illegal
);

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd_f, shamt;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic [31:0] jalr_sum;
   logic        f7_zero, f7_alt;
   logic        is_lui, is_auipc, is_jal, is_jalr;
   logic        is_br, is_load, is_store, is_imm, is_reg;
   logic        bad, wr;
   issue_t      dec, head;

   assign opc   = instruction[6:0];
   assign rd_f  = instruction[11:7];
   assign f3    = instruction[14:12];
   assign shamt = instruction[24:20];
   assign f7    = instruction[31:25];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25],
                   instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31],
                   instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31],
                   instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
   assign imm_u = {instruction[31:12], 12'b0};

   assign jalr_sum = rs1_data + imm_i;

   assign f7_zero = (f7 == 7'h00);
   assign f7_alt  = (f7 == 7'h20);

   assign is_lui   = (opc == OP_LUI);
   assign is_auipc = (opc == OP_AUIPC);
   assign is_jal   = (opc == OP_JAL);
   assign is_jalr  = (opc == OP_JALR);
   assign is_br    = (opc == OP_BRANCH);
   assign is_load  = (opc == OP_LOAD);
   assign is_store = (opc == OP_STORE);
   assign is_imm   = (opc == OP_IMM);
   assign is_reg   = (opc == OP_REG);

   // combinational decode and operand selection
   always_comb begin
      dec = '0;
      bad = 1'b0;
      wr  = 1'b0;
      unique case (1'b1)
         is_lui: begin
            dec.op_a = imm_u;
            wr       = 1'b1;
         end
         is_auipc: begin
            dec.op_a = pc;
            dec.op_b = imm_u;
            wr       = 1'b1;
         end
         is_jal: begin
            dec.alu_ctrl = ALU_JAL;
            dec.op_a     = pc + 32'd4;
            dec.target   = pc + imm_j;
            wr           = 1'b1;
         end
         is_jalr: begin
            dec.alu_ctrl = ALU_JALR;
            dec.op_a     = pc + 32'd4;
            dec.target   = {jalr_sum[31:1], 1'b0};
            wr           = 1'b1;
         end
         is_br: begin
            dec.op_a      = rs1_data;
            dec.op_b      = rs2_data;
            dec.branch_op = 1'b1;
            dec.target    = pc + imm_b;
            case (f3)
               3'b000:  dec.alu_ctrl = ALU_BEQ;
               3'b001:  dec.alu_ctrl = ALU_BNE;
               3'b100:  dec.alu_ctrl = ALU_SLT;
               3'b101:  dec.alu_ctrl = ALU_BGE;
               3'b110:  dec.alu_ctrl = ALU_BLTU;
               3'b111:  dec.alu_ctrl = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         is_load: begin
            dec.op_a = rs1_data;
            dec.op_b = imm_i;
            wr       = 1'b1;
         end
         is_store: begin
            dec.op_a = rs1_data;
            dec.op_b = imm_s;
         end
         is_imm: begin
            dec.op_a     = rs1_data;
            dec.alu_ctrl = arith_ctrl(f3, f7_alt && f3 == 3'b101);
            wr           = 1'b1;
            if (f3 == 3'b001 || f3 == 3'b101) begin
               dec.op_b = {27'b0, shamt};
               bad      = !(f7_zero || (f7_alt && f3 == 3'b101));
            end else begin
               dec.op_b = imm_i;
            end
         end
         is_reg: begin
            dec.op_a     = rs1_data;
            dec.op_b     = rs2_data;
            dec.alu_ctrl = arith_ctrl(f3, f7_alt);
            wr           = 1'b1;
            bad          = !(f7_zero || (f7_alt &&
                              (f3 == 3'b000 || f3 == 3'b101)));
         end
         default: bad = 1'b1;
      endcase
      dec.rd        = wr ? rd_f : 5'd0;
      dec.reg_write = wr && (rd_f != 5'd0);
      if (bad) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   issue_skid_buffer u_skid (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign ALU_Control = head.alu_ctrl;
   assign operand_A   = head.op_a;
   assign operand_B   = head.op_b;
   assign branch_op   = head.branch_op;
   assign target      = head.target;
   assign rd          = head.rd;
   assign reg_write   = head.reg_write;
   assign illegal     = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors for alu_issue with
// hand-computed expectations.
module tb_alu_issue;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  ALU_Control;
   logic [31:0] operand_A;
   logic [31:0] operand_B;
   logic        branch_op;
   logic [31:0] target;
   logic [4:0]  rd;
   logic        reg_write;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;

   alu_issue dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .pc          (pc),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALU_Control (ALU_Control),
      .operand_A   (operand_A),
      .operand_B   (operand_B),
      .branch_op   (branch_op),
      .target      (target),
      .rd          (rd),
      .reg_write   (reg_write),
      .illegal     (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(
      input logic [31:0] ins,
      input logic [31:0] p,
      input logic [31:0] a,
      input logic [31:0] b
   );
      in_valid    = 1'b1;
      instruction = ins;
      pc          = p;
      rs1_data    = a;
      rs2_data    = b;
   endtask

   task automatic issue(
      input logic [31:0] ins,
      input logic [31:0] p,
      input logic [31:0] a,
      input logic [31:0] b
   );
      drive(ins, p, a, b);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      instruction = '0;
      pc          = '0;
      rs1_data    = '0;
      rs2_data    = '0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_ctrl", ALU_Control, 0);
      check("rst_a", operand_A, 0);
      check("rst_b", operand_B, 0);
      check("rst_target", target, 0);
      reset_n = 1'b1;
      tick();

      // ADDI x1,x2,5
      issue(32'h00510093, 32'h0, 32'd10, 32'd0);
      check("addi_valid", out_valid, 1);
      check("addi_ctrl", ALU_Control, 6'b000000);
      check("addi_a", operand_A, 10);
      check("addi_b", operand_B, 5);
      check("addi_rd", rd, 1);
      check("addi_we", reg_write, 1);

      // SUB x3,x1,x2
      issue(32'h402081B3, 32'h4, 32'd7, 32'd3);
      check("sub_ctrl", ALU_Control, 6'b001000);
      check("sub_a", operand_A, 7);
      check("sub_b", operand_B, 3);
      check("sub_rd", rd, 3);

      // BLT x1,x2,+8
      issue(32'h0020C463, 32'h100, 32'd1, 32'd2);
      check("blt_ctrl", ALU_Control, 6'b000010);
      check("blt_br", branch_op, 1);
      check("blt_tgt", target, 32'h108);
      check("blt_we", reg_write, 0);
      check("blt_b", operand_B, 2);

      // JAL x1,+16
      issue(32'h010000EF, 32'h200, 32'd0, 32'd0);
      check("jal_ctrl", ALU_Control, 6'b011111);
      check("jal_a", operand_A, 32'h204);
      check("jal_b", operand_B, 0);
      check("jal_tgt", target, 32'h210);
      check("jal_rd", rd, 1);
      check("jal_br", branch_op, 0);

      // SRAI x5,x6,3
      issue(32'h40335293, 32'h0, 32'h80000000, 32'd0);
      check("srai_ctrl", ALU_Control, 6'b001101);
      check("srai_b", operand_B, 3);

      // LUI x2,0x12345
      issue(32'h12345137, 32'h0, 32'd9, 32'd0);
      check("lui_a", operand_A, 32'h12345000);
      check("lui_b", operand_B, 0);

      // ADDI x0,x0,5 does not write
      issue(32'h00500013, 32'h0, 32'd0, 32'd0);
      check("x0_we", reg_write, 0);

      tick();
      check("drain_valid", out_valid, 0);

      // backpressure: three back-to-back pushes
      out_ready = 1'b0;
      drive(32'h00510093, 32'h0, 32'd1, 32'd0);
      tick();
      check("bp1_valid", out_valid, 1);
      check("bp1_rdy", in_ready, 1);
      drive(32'h00510093, 32'h0, 32'd2, 32'd0);
      tick();
      check("bp2_rdy", in_ready, 0);
      check("bp2_a", operand_A, 1);
      drive(32'h00510093, 32'h0, 32'd3, 32'd0);
      tick();
      check("bp3_rdy", in_ready, 0);
      check("bp3_a", operand_A, 1);
      out_ready = 1'b1;
      tick();
      check("dr1_a", operand_A, 2);
      check("dr1_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("dr2_a", operand_A, 3);
      check("dr2_valid", out_valid, 1);
      tick();
      check("dr3_valid", out_valid, 0);
      check("dr3_rdy", in_ready, 1);

      // flush with buffer full
      out_ready = 1'b0;
      issue(32'h00510093, 32'h0, 32'h11, 32'd0);
      issue(32'h00510093, 32'h0, 32'h22, 32'd0);
      check("fl_full", in_ready, 0);
      drive(32'h00510093, 32'h0, 32'h33, 32'd0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl2_valid", out_valid, 0);
      check("fl2_rdy", in_ready, 1);
      tick();
      check("fl2_gone", out_valid, 0);

      // flush drops a same-cycle push into a one-entry buffer
      issue(32'h00510093, 32'h0, 32'h44, 32'd0);
      drive(32'h00510093, 32'h0, 32'h55, 32'd0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl1_valid", out_valid, 0);
      tick();
      check("fl1_gone", out_valid, 0);
      out_ready = 1'b1;

      // unknown opcode
      issue(32'h0000007F, 32'h0, 32'd5, 32'd6);
      check("ill_op", illegal, 1);
      check("ill_op_we", reg_write, 0);
      check("ill_op_ctrl", ALU_Control, 0);
      check("ill_op_a", operand_A, 0);
      check("ill_op_b", operand_B, 0);

      // ADD with funct7 = 0x01
      issue(32'h022081B3, 32'h0, 32'd5, 32'd6);
      check("ill_f7", illegal, 1);
      check("ill_f7_we", reg_write, 0);
      check("ill_f7_ctrl", ALU_Control, 0);

      // legal after illegal clears the flag
      issue(32'h402081B3, 32'h0, 32'd8, 32'd1);
      check("legal_again", illegal, 0);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      issue(32'h00510093, 32'h0, 32'd9, 32'd0);
      issue(32'h00510093, 32'h0, 32'd9, 32'd0);
      check("pre_rst_valid", out_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_rdy", in_ready, 1);
      check("arst_a", operand_A, 0);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_rst_rdy", in_ready, 1);
      check("post_rst_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
